lsu_arbiter: RTL and testbench

- Shares the single lsu port between two requesters: m0 (core data port) and m1 (debug/boot loader that preloads data memory and pokes I/O).
- Sits between the requesters and lsu, and drives lsu's address, store-data and write-enable inputs.
- Round-robin arbitration with an optional lock, so a requester can do back-to-back (read-modify-write) accesses; the lock has a bounded hold time.
- One transfer per cycle. Response is registered and returned one cycle after acceptance.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/lsu_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_lsu_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the two-master lsu port arbiter.
package lsu_pkg;

  // Arbiter ownership state: free round-robin or locked to one master.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int unsigned LSU_ADDR_W_DEF   = 32;
  localparam int unsigned LSU_DATA_W_DEF   = 32;
  localparam int unsigned LSU_LOCK_MAX_DEF = 16;

  // Encoding of last_grant: which master was served most recently.
  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  // One requester's transfer as seen at the default widths.
  typedef struct packed {
    logic [LSU_ADDR_W_DEF-1:0] addr;
    logic [LSU_DATA_W_DEF-1:0] wdata;
    logic                      wren;
    logic                      lock;
  } lsu_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker with one-hot grant output.
module rr_pick2
  import lsu_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // A lone requester wins; on a tie the master not served last wins.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == GRANT_M1) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one lsu port between m0 (core) and m1 (debug/boot loader) with
// round-robin arbitration, bounded lock for RMW sequences and a registered
// one-cycle response path.
module lsu_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W   = LSU_ADDR_W_DEF,
  parameter int unsigned DATA_W   = LSU_DATA_W_DEF,
  parameter int unsigned LOCK_MAX = LSU_LOCK_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_m0_valid,
  output logic              o_m0_ready,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m0_wren,
  input  logic              i_m0_lock,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_valid,
  output logic              o_m1_ready,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic              i_m1_wren,
  input  logic              i_m1_lock,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_st_data,
  output logic              o_lsu_wren,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_lock_abort
);

  localparam int unsigned CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              abort_q, abort_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic [1:0]        pick_valid_s;
  logic [1:0]        grant_s;
  logic              acc_s;
  logic              win_s;
  logic              win_wren_s;
  logic              win_lock_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic              owner_valid_s;
  logic              owner_lock_s;
  logic [DATA_W-1:0] resp_data_s;

  // Mask the picker inputs so a locked state only lets its owner through.
  always_comb begin
    pick_valid_s = 2'b00;
    case (state_q)
      IDLE:    pick_valid_s = {i_m1_valid, i_m0_valid};
      OWN0:    pick_valid_s = {1'b0, i_m0_valid};
      OWN1:    pick_valid_s = {i_m1_valid, 1'b0};
      default: pick_valid_s = 2'b00;
    endcase
  end

  rr_pick2 u_pick (
    .valid_i      (pick_valid_s),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_s)
  );

  assign o_m0_ready = i_m0_valid & grant_s[0];
  assign o_m1_ready = i_m1_valid & grant_s[1];
  assign acc_s      = o_m0_ready | o_m1_ready;
  assign win_s      = grant_s[1];

  // Select the winning request and the owner's current request fields.
  always_comb begin
    if (win_s) begin
      win_addr_s  = i_m1_addr;
      win_wdata_s = i_m1_wdata;
      win_wren_s  = i_m1_wren;
      win_lock_s  = i_m1_lock;
    end else begin
      win_addr_s  = i_m0_addr;
      win_wdata_s = i_m0_wdata;
      win_wren_s  = i_m0_wren;
      win_lock_s  = i_m0_lock;
    end
    if (state_q == OWN1) begin
      owner_valid_s = i_m1_valid;
      owner_lock_s  = i_m1_lock;
    end else begin
      owner_valid_s = i_m0_valid;
      owner_lock_s  = i_m0_lock;
    end
  end

  // Drive the lsu only while a transfer is granted; otherwise park at zero.
  always_comb begin
    if (acc_s) begin
      o_lsu_addr = win_addr_s;
      o_st_data  = win_wdata_s;
      o_lsu_wren = win_wren_s;
    end else begin
      o_lsu_addr = {ADDR_W{1'b0}};
      o_st_data  = {DATA_W{1'b0}};
      o_lsu_wren = 1'b0;
    end
  end

  // Ownership FSM, lock hold counter and forced-release detection.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    last_grant_d = last_grant_q;
    abort_d      = 1'b0;
    if (acc_s) begin
      last_grant_d = win_s;
    end else begin
      last_grant_d = last_grant_q;
    end
    case (state_q)
      IDLE: begin
        lock_cnt_d = {CNT_W{1'b0}};
        if (acc_s && win_lock_s) begin
          state_d = win_s ? OWN1 : OWN0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        // Saturating count of cycles spent owning the port.
        if (lock_cnt_q == CNT_LAST) begin
          lock_cnt_d = lock_cnt_q;
        end else begin
          lock_cnt_d = lock_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (acc_s && !win_lock_s) begin
          state_d    = IDLE;
          lock_cnt_d = {CNT_W{1'b0}};
        end else if (!owner_valid_s && !owner_lock_s) begin
          state_d    = IDLE;
          lock_cnt_d = {CNT_W{1'b0}};
        end else if (lock_cnt_q == CNT_LAST) begin
          // Owner overstayed: drop the lock and hand the next tie away.
          state_d      = IDLE;
          lock_cnt_d   = {CNT_W{1'b0}};
          abort_d      = 1'b1;
          last_grant_d = (state_q == OWN1) ? GRANT_M1 : GRANT_M0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Response capture: strobe the winner and hold the loser's last data.
  always_comb begin
    resp_data_s = win_wren_s ? {DATA_W{1'b0}} : i_ld_data;
    m0_rvalid_d = o_m0_ready;
    m1_rvalid_d = o_m1_ready;
    if (o_m0_ready) begin
      m0_rdata_d = resp_data_s;
    end else begin
      m0_rdata_d = m0_rdata_q;
    end
    if (o_m1_ready) begin
      m1_rdata_d = resp_data_s;
    end else begin
      m1_rdata_d = m1_rdata_q;
    end
  end

  // State and response registers; async reset drops any pending response.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_M1;
      lock_cnt_q   <= {CNT_W{1'b0}};
      abort_q      <= 1'b0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_rdata_q   <= {DATA_W{1'b0}};
      m1_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      abort_q      <= abort_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign o_m0_rvalid  = m0_rvalid_q;
  assign o_m1_rvalid  = m1_rvalid_q;
  assign o_m0_rdata   = m0_rdata_q;
  assign o_m1_rdata   = m1_rdata_q;
  assign o_lock_abort = abort_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed self-checking bench for lsu_arbiter.
module tb_lsu_arbiter;
  import lsu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_m0_valid, i_m0_wren, i_m0_lock;
  logic [AW-1:0] i_m0_addr;
  logic [DW-1:0] i_m0_wdata;
  logic          i_m1_valid, i_m1_wren, i_m1_lock;
  logic [AW-1:0] i_m1_addr;
  logic [DW-1:0] i_m1_wdata;
  logic [DW-1:0] i_ld_data;
  logic          o_m0_ready, o_m0_rvalid, o_m1_ready, o_m1_rvalid;
  logic [DW-1:0] o_m0_rdata, o_m1_rdata, o_st_data;
  logic [AW-1:0] o_lsu_addr;
  logic          o_lsu_wren, o_lock_abort;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_valid(i_m0_valid), .o_m0_ready(o_m0_ready), .i_m0_addr(i_m0_addr),
    .i_m0_wdata(i_m0_wdata), .i_m0_wren(i_m0_wren), .i_m0_lock(i_m0_lock),
    .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_valid(i_m1_valid), .o_m1_ready(o_m1_ready), .i_m1_addr(i_m1_addr),
    .i_m1_wdata(i_m1_wdata), .i_m1_wren(i_m1_wren), .i_m1_lock(i_m1_lock),
    .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data), .o_lsu_wren(o_lsu_wren),
    .i_ld_data(i_ld_data), .o_lock_abort(o_lock_abort)
  );

  // Requesters must hold their request stable while stalled.
  logic          m0_pend = 1'b0, m1_pend = 1'b0;
  logic [AW+DW+1:0] m0_snap, m1_snap;
  always @(negedge clk) begin
    if (rst_n && m0_pend && i_m0_valid)
      assert ({i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_lock} == m0_snap)
      else $error("FAIL m0_hold_stable request changed while stalled");
    if (rst_n && m1_pend && i_m1_valid)
      assert ({i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_lock} == m1_snap)
      else $error("FAIL m1_hold_stable request changed while stalled");
    m0_pend <= rst_n && i_m0_valid && !o_m0_ready;
    m1_pend <= rst_n && i_m1_valid && !o_m1_ready;
    m0_snap <= {i_m0_addr, i_m0_wdata, i_m0_wren, i_m0_lock};
    m1_snap <= {i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_lock};
  end

  task automatic clear_inputs();
    i_m0_valid = 1'b0; i_m0_wren = 1'b0; i_m0_lock = 1'b0;
    i_m0_addr = 32'h0; i_m0_wdata = 32'h0;
    i_m1_valid = 1'b0; i_m1_wren = 1'b0; i_m1_lock = 1'b0;
    i_m1_addr = 32'h0; i_m1_wdata = 32'h0;
    i_ld_data = 32'h0;
  endtask

  // Leaves the bench 1 time unit after a posedge, ready to drive a cycle.
  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE);
    end
    checks++;
    if (dut.last_grant_q !== 1'b1) begin
      failures++; $display("FAIL reset_last_grant got=%0b exp=1", dut.last_grant_q);
    end
    checks++;
    if ({o_m0_rvalid, o_m1_rvalid, o_lock_abort} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000", {o_m0_rvalid, o_m1_rvalid, o_lock_abort});
    end
    checks++;
    if (o_m0_rdata !== 32'h0 || o_m1_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", o_m0_rdata, o_m1_rdata);
    end
    next_cycle();
  endtask

  task automatic test_single_load();
    apply_reset();
    i_m0_valid = 1'b1; i_m0_addr = 32'h0000_0010; i_m0_wren = 1'b0;
    i_ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (o_m0_ready !== 1'b1 || o_m1_ready !== 1'b0) begin
      failures++; $display("FAIL load_ready got=%b%b exp=10", o_m0_ready, o_m1_ready);
    end
    checks++;
    if (o_lsu_addr !== 32'h0000_0010 || o_lsu_wren !== 1'b0) begin
      failures++; $display("FAIL load_lsu_drive got=%h/%b exp=00000010/0", o_lsu_addr, o_lsu_wren);
    end
    next_cycle();
    i_m0_valid = 1'b0; i_ld_data = 32'h0;
    @(negedge clk);
    checks++;
    if (o_m0_rvalid !== 1'b1 || o_m0_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL load_resp got=%b/%h exp=1/deadbeef", o_m0_rvalid, o_m0_rdata);
    end
    checks++;
    if (o_m1_rvalid !== 1'b0) begin
      failures++; $display("FAIL load_m1_quiet got=%b exp=0", o_m1_rvalid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_m0_rvalid !== 1'b0 || o_m0_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL load_rdata_hold got=%b/%h exp=0/deadbeef", o_m0_rvalid, o_m0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    logic exp0;
    apply_reset();
    i_m0_valid = 1'b1; i_m0_addr = 32'h1000_0000; i_m0_wdata = 32'h5; i_m0_wren = 1'b1;
    i_m1_valid = 1'b1; i_m1_addr = 32'h1001_0000; i_m1_wren = 1'b0;
    i_ld_data = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      exp0 = ((i % 2) == 0);
      @(negedge clk);
      checks++;
      if (o_m0_ready !== exp0 || o_m1_ready !== !exp0) begin
        failures++; $display("FAIL alt_grant cyc=%0d got=%b%b exp=%b%b", i, o_m0_ready, o_m1_ready, exp0, !exp0);
      end
      checks++;
      if (o_lsu_wren !== exp0 || o_lsu_addr !== (exp0 ? 32'h1000_0000 : 32'h1001_0000)
          || o_st_data !== (exp0 ? 32'h5 : 32'h0)) begin
        failures++; $display("FAIL alt_lsu cyc=%0d got=%b/%h/%h", i, o_lsu_wren, o_lsu_addr, o_st_data);
      end
      if (i > 0) begin
        checks++;
        if (o_m0_rvalid !== !exp0 || o_m1_rvalid !== exp0) begin
          failures++; $display("FAIL alt_rvalid cyc=%0d got=%b%b exp=%b%b", i, o_m0_rvalid, o_m1_rvalid, !exp0, exp0);
        end
        checks++;
        if (o_m0_rdata !== 32'h0 || (exp0 && o_m1_rdata !== 32'hCAFE_F00D)) begin
          failures++; $display("FAIL alt_rdata cyc=%0d got=%h/%h", i, o_m0_rdata, o_m1_rdata);
        end
      end
      next_cycle();
    end
    i_m0_valid = 1'b0; i_m1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_m1_rvalid !== 1'b1 || o_m1_rdata !== 32'hCAFE_F00D || o_m0_rvalid !== 1'b0) begin
      failures++; $display("FAIL alt_last_resp got=%b/%h/%b exp=1/cafef00d/0", o_m1_rvalid, o_m1_rdata, o_m0_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_lock_rmw();
    apply_reset();
    i_m0_valid = 1'b1; i_m0_addr = 32'h0000_0020; i_m0_wren = 1'b0; i_m0_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (o_m0_ready !== 1'b1) begin
      failures++; $display("FAIL rmw_pre got=%b exp=1", o_m0_ready);
    end
    next_cycle();
    i_m1_valid = 1'b1; i_m1_addr = 32'h3000_0000; i_m1_wdata = 32'hA5; i_m1_wren = 1'b1; i_m1_lock = 1'b1;
    @(negedge clk);
    checks++;
    if (o_m1_ready !== 1'b1 || o_m0_ready !== 1'b0 || o_lsu_wren !== 1'b1) begin
      failures++; $display("FAIL rmw_store got=%b%b/%b exp=10/1", o_m1_ready, o_m0_ready, o_lsu_wren);
    end
    next_cycle();
    i_m1_wren = 1'b0; i_m1_lock = 1'b0; i_ld_data = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (dut.state_q !== OWN1) begin
      failures++; $display("FAIL rmw_own1 got=%0d exp=%0d", dut.state_q, OWN1);
    end
    checks++;
    if (o_m1_ready !== 1'b1 || o_m0_ready !== 1'b0 || o_lsu_wren !== 1'b0) begin
      failures++; $display("FAIL rmw_load got=%b%b/%b exp=10/0", o_m1_ready, o_m0_ready, o_lsu_wren);
    end
    checks++;
    if (o_m1_rvalid !== 1'b1 || o_m1_rdata !== 32'h0) begin
      failures++; $display("FAIL rmw_store_ack got=%b/%h exp=1/0", o_m1_rvalid, o_m1_rdata);
    end
    next_cycle();
    i_m1_valid = 1'b0; i_ld_data = 32'h0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE || o_m0_ready !== 1'b1) begin
      failures++; $display("FAIL rmw_release got=%0d/%b exp=%0d/1", dut.state_q, o_m0_ready, IDLE);
    end
    checks++;
    if (o_m1_rvalid !== 1'b1 || o_m1_rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL rmw_load_resp got=%b/%h exp=1/12345678", o_m1_rvalid, o_m1_rdata);
    end
    next_cycle();
    // Owner drops valid and lock together: lock released without abort.
    i_m0_lock = 1'b1;
    @(negedge clk);
    next_cycle();
    i_m0_valid = 1'b0; i_m0_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== OWN0) begin
      failures++; $display("FAIL idle_rel_own0 got=%0d exp=%0d", dut.state_q, OWN0);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE || o_lock_abort !== 1'b0) begin
      failures++; $display("FAIL idle_rel got=%0d/%b exp=%0d/0", dut.state_q, o_lock_abort, IDLE);
    end
    next_cycle();
  endtask

  task automatic test_lock_timeout();
    int aborts;
    aborts = 0;
    apply_reset();
    i_m0_valid = 1'b1; i_m0_addr = 32'h40; i_m0_lock = 1'b1;
    i_m1_valid = 1'b1; i_m1_addr = 32'h50;
    i_ld_data = 32'h0BAD_F00D;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_lock_abort === 1'b1) aborts++;
      checks++;
      if (o_m1_ready !== (c == 17) || o_m0_ready !== (c != 17)) begin
        failures++; $display("FAIL lock_grant cyc=%0d got=%b%b exp=%b%b", c, o_m0_ready, o_m1_ready, c != 17, c == 17);
      end
      checks++;
      if (o_lock_abort !== (c == 17)) begin
        failures++; $display("FAIL lock_abort cyc=%0d got=%b exp=%b", c, o_lock_abort, c == 17);
      end
      if (c == 16) begin
        checks++;
        if (dut.state_q !== OWN0) begin
          failures++; $display("FAIL lock_last_own got=%0d exp=%0d", dut.state_q, OWN0);
        end
      end
      if (c == 17) begin
        checks++;
        if (dut.state_q !== IDLE || o_m0_rvalid !== 1'b1 || o_m0_rdata !== 32'h0BAD_F00D) begin
          failures++; $display("FAIL lock_forced_xfer got=%0d/%b/%h exp=%0d/1/0badf00d", dut.state_q, o_m0_rvalid, o_m0_rdata, IDLE);
        end
      end
      next_cycle();
    end
    checks++;
    if (aborts !== 1) begin
      failures++; $display("FAIL lock_abort_count got=%0d exp=1", aborts);
    end
    i_m0_valid = 1'b0; i_m0_lock = 1'b0; i_m1_valid = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_idle();
    apply_reset();
    i_m0_addr = 32'hFFFF_0000; i_m0_wdata = 32'h1111_2222; i_m0_wren = 1'b1;
    i_m1_addr = 32'hEEEE_0000; i_m1_wren = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (o_lsu_wren !== 1'b0 || o_lsu_addr !== 32'h0 || o_st_data !== 32'h0) begin
        failures++; $display("FAIL idle_lsu cyc=%0d got=%b/%h/%h exp=0/0/0", c, o_lsu_wren, o_lsu_addr, o_st_data);
      end
      checks++;
      if ({o_m0_ready, o_m1_ready, o_m0_rvalid, o_m1_rvalid} !== 4'b0000) begin
        failures++; $display("FAIL idle_strobes cyc=%0d got=%b exp=0000", c, {o_m0_ready, o_m1_ready, o_m0_rvalid, o_m1_rvalid});
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_m1_valid = 1'b1; i_m1_addr = 32'h60; i_m1_wdata = 32'h7; i_m1_wren = 1'b1; i_m1_lock = 1'b1;
    @(negedge clk);
    checks++;
    if (o_m1_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_grant got=%b exp=1", o_m1_ready);
    end
    next_cycle();
    #1;
    checks++;
    if (o_m1_rvalid !== 1'b1 || dut.state_q !== OWN1) begin
      failures++; $display("FAIL rst_mid_pre got=%b/%0d exp=1/%0d", o_m1_rvalid, dut.state_q, OWN1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_m0_rvalid !== 1'b0 || o_m1_rvalid !== 1'b0 || dut.state_q !== IDLE) begin
      failures++; $display("FAIL rst_mid_async got=%b%b/%0d exp=00/%0d", o_m0_rvalid, o_m1_rvalid, dut.state_q, IDLE);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    i_m0_valid = 1'b1; i_m0_addr = 32'h70;
    i_m1_valid = 1'b1; i_m1_addr = 32'h80;
    @(negedge clk);
    checks++;
    if (o_m0_ready !== 1'b1 || o_m1_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid_tie got=%b%b exp=10", o_m0_ready, o_m1_ready);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_load();
    test_alternate();
    test_lock_rmw();
    test_lock_timeout();
    test_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
